capt_sched: RTL and testbench
=============================

Name: capt_sched

Overview:
- Capture scheduler that sequences the DMA packet writer (wr_ctrl) in the capture path.
- Takes packet descriptors (begin/end byte offsets) from the packet detector and queues them in a small FIFO.
- Issues them one at a time to the writer with a wr_ctrl start pulse and waits for the writer's done pulse.
- Keeps packet, byte, wrap and drop statistics, enforces a packet-count limit and a watchdog timeout, and raises interrupts.

Parameters:
- DEPTH, 4, descriptor FIFO entries; power of two, minimum 2.
- MAX_PKT_BYTES, 16'd2048, largest accepted packet length in bytes.
- TIMEOUT_CYCLES, 16'd65535, cycles allowed between wr_ctrl and wr_ctrl_rdy.

Ports:
- clk in 1: single clock.
- reset in 1: asynchronous, active-high reset.
- ctrl_enable in 1: capture enable, level.
- ctrl_clear in 1: one-cycle pulse; clears counters, error and halt, and flushes the FIFO.
- max_pkts in 32: packet limit; 0 means unlimited.
- desc_valid in 1: descriptor strobe.
- desc_ready out 1: always 1 out of reset; this block never back-pressures.
- desc_begin in 32: packet start offset.
- desc_end in 32: packet end offset (exclusive).
- wr_ctrl out 1: one-cycle start pulse to the writer.
- wr_ctrl_rdy in 1: one-cycle done pulse from the writer.
- capt_buf_wrap in 1: writer wrap flag, sampled on wr_ctrl_rdy.
- pkt_begin out 32: operand to the writer.
- pkt_end out 32: operand to the writer.
- busy out 1: high in ISSUE or WAIT.
- pkt_count out 32: packets retired.
- byte_count out 32: bytes retired.
- wrap_count out 16: retirements with capt_buf_wrap set.
- drop_count out 32: descriptors dropped.
- err out 1: sticky timeout flag.
- irq_done out 1: one-cycle pulse when the packet limit is reached.
- irq_err out 1: one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0 except desc_ready=0 during reset and 1 after. FIFO empty, FSM in IDLE, timeout counter 0.
- Descriptor length: len = desc_end - desc_begin, 32-bit unsigned.
- Drop conditions: a descriptor with desc_valid=1 is dropped (drop_count+1, not queued) if any of these hold:
  - ctrl_enable=0;
  - FSM in HALT or ERROR;
  - len==0 or len>MAX_PKT_BYTES (this also covers desc_end<desc_begin through unsigned wrap);
  - FIFO full with no pop in the same cycle.
- FIFO full with a pop in the same cycle: the push is accepted.
- FSM states: IDLE, ISSUE, WAIT, RETIRE, HALT, ERROR.
- IDLE -> ISSUE when ctrl_enable=1 and the FIFO is not empty. On that edge: pop the head, register pkt_begin/pkt_end from it, and set wr_ctrl=1.
  - pkt_begin, pkt_end and wr_ctrl are therefore all valid in the same ISSUE cycle.
  - pkt_begin/pkt_end hold until the next issue.
- ISSUE -> WAIT unconditionally. wr_ctrl deasserts and the timeout counter loads TIMEOUT_CYCLES.
- WAIT:
  - wr_ctrl_rdy=1 -> RETIRE. Latch capt_buf_wrap.
  - Otherwise the counter decrements; reaching 0 -> ERROR.
  - wr_ctrl_rdy in the same cycle as expiry: rdy wins.
- RETIRE (one cycle): pkt_count+1, byte_count += registered len, wrap_count+1 if the latched wrap was set.
  - Then -> HALT with irq_done=1 if max_pkts!=0 and the new pkt_count==max_pkts.
  - Otherwise -> IDLE.
- Counter width: all counters wrap modulo 2^width, no saturation.
- HALT: no issue and no queueing. Exit to IDLE only on ctrl_clear.
- ERROR: entered with err=1 and a one-cycle irq_err. Exit to IDLE only on ctrl_clear; err clears at the same time.
- ctrl_clear effects:
  - Zeroes pkt/byte/wrap/drop counters and err, and flushes the FIFO.
  - Takes HALT/ERROR to IDLE.
  - Does not abort ISSUE/WAIT; the in-flight packet completes and is counted in RETIRE.
  - If it coincides with a counter increment or a drop, the clear wins (result 0).
  - A push in the same cycle as ctrl_clear is discarded without being counted.
- ctrl_enable deasserted mid-transfer: the current packet completes, queued descriptors remain, and no new issue occurs until re-enabled.
- Reset asserted mid-transfer: immediate return to reset values; the writer is not notified.
- busy reflects FSM state combinationally from registers. Outputs are registered.

Test Plan:
- Single packet: enable, one descriptor begin=0x100/end=0x140, writer returns rdy 20 cycles after wr_ctrl -> one wr_ctrl pulse with pkt_begin=0x100/pkt_end=0x140 in the same cycle; pkt_count=1, byte_count=64, busy high for 21 cycles.
- Burst: 6 back-to-back descriptors with DEPTH=4 and the writer stalled -> first popped, 4 queued, sixth dropped; drop_count=1; later 5 retirements in order.
- Invalid lengths: end==begin, end<begin, len=2049 -> drop_count=3, no wr_ctrl.
- Limit: max_pkts=2, 3 descriptors -> irq_done once after the second retire; state HALT; third descriptor dropped; ctrl_clear -> counters 0, IDLE.
- Timeout: TIMEOUT_CYCLES=8, no rdy -> irq_err 8 cycles after WAIT entry, err=1, pending FIFO not issued. Also rdy on the expiry cycle -> RETIRE, err=0.
- Wrap/clear collision: rdy with capt_buf_wrap=1 -> wrap_count=1. Then ctrl_clear in the RETIRE cycle -> all counters 0.

Source files
------------

// File: rtl/capt_sched_if.sv
// Descriptor and writer handshake bundle between the packet detector, the
// capture scheduler and the DMA packet writer.
interface capt_sched_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_begin;
  logic [31:0] desc_end;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy;
  logic        capt_buf_wrap;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;

  // master drives descriptors and writer completions; slave is the scheduler
  modport master (
    output desc_valid, desc_begin, desc_end, wr_ctrl_rdy, capt_buf_wrap,
    input  desc_ready, wr_ctrl, pkt_begin, pkt_end
  );

  modport slave (
    input  desc_valid, desc_begin, desc_end, wr_ctrl_rdy, capt_buf_wrap,
    output desc_ready, wr_ctrl, pkt_begin, pkt_end
  );
endinterface

// File: rtl/capt_sched.sv
// Capture scheduler: queues packet descriptors and hands them one at a time to
// the DMA packet writer, with statistics, a packet limit and a watchdog.
module capt_sched #(
  parameter int          DEPTH          = 4,
  parameter logic [15:0] MAX_PKT_BYTES  = 16'd2048,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_enable,
  input  logic               ctrl_clear,
  input  logic [31:0]        max_pkts,
  capt_sched_if.slave        bus,
  output logic               busy,
  output logic [31:0]        pkt_count,
  output logic [31:0]        byte_count,
  output logic [15:0]        wrap_count,
  output logic [31:0]        drop_count,
  output logic               err,
  output logic               irq_done,
  output logic               irq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RETIRE, S_HALT, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem_begin [DEPTH];
  logic [31:0]   mem_end   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;

  logic [31:0] desc_len;
  logic        len_ok, accept_state;
  logic        push, pop, drop, retire, expire, limit_hit;
  logic [31:0] pkt_next;

  logic        ready_q, wr_ctrl_q, wrap_q;
  logic [31:0] pkt_begin_q, pkt_end_q, len_q;
  logic [15:0] tmo_cnt;

  assign bus.desc_ready = ready_q;
  assign bus.wr_ctrl    = wr_ctrl_q;
  assign bus.pkt_begin  = pkt_begin_q;
  assign bus.pkt_end    = pkt_end_q;

  assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // NOTE: every signal driven here gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    retire       = 1'b0;
    expire       = 1'b0;
    desc_len     = bus.desc_end - bus.desc_begin;
    len_ok       = (desc_len != 32'd0) && (desc_len <= {16'd0, MAX_PKT_BYTES});
    fifo_empty   = (fifo_cnt == '0);
    fifo_full    = (fifo_cnt == DEPTH_C);
    pkt_next     = pkt_count + 32'd1;
    limit_hit    = (max_pkts != 32'd0) && (pkt_next == max_pkts);

    unique case (state_q)
      S_IDLE: begin
        // a clear flushes the queue, so nothing is issued in that cycle
        if (ctrl_enable && !fifo_empty && !ctrl_clear) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.wr_ctrl_rdy) begin
          state_d = S_RETIRE;
        end else if (tmo_cnt <= 16'd1) begin
          expire  = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_RETIRE: begin
        retire  = 1'b1;
        state_d = limit_hit ? S_HALT : S_IDLE;
      end
      S_HALT, S_ERROR: begin
        if (ctrl_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    accept_state = ctrl_enable && (state_q != S_HALT) && (state_q != S_ERROR);
    push = bus.desc_valid && !ctrl_clear && accept_state && len_ok && (!fifo_full || pop);
    drop = bus.desc_valid && !ctrl_clear && !push;
  end

  // NOTE: descriptor storage is not reset; occupancy is tracked by the pointers
  // and count, so stale entries are never read and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_begin[wr_ptr] <= bus.desc_begin;
      mem_end[wr_ptr]   <= bus.desc_end;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      wr_ctrl_q   <= 1'b0;
      pkt_begin_q <= '0;
      pkt_end_q   <= '0;
      len_q       <= '0;
      wrap_q      <= 1'b0;
      tmo_cnt     <= '0;
      pkt_count   <= '0;
      byte_count  <= '0;
      wrap_count  <= '0;
      drop_count  <= '0;
      err         <= 1'b0;
      irq_done    <= 1'b0;
      irq_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      wr_ctrl_q <= pop;
      irq_done  <= retire && limit_hit;
      irq_err   <= expire;

      if (ctrl_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
          2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end

      if (pop) begin
        pkt_begin_q <= mem_begin[rd_ptr];
        pkt_end_q   <= mem_end[rd_ptr];
        len_q       <= mem_end[rd_ptr] - mem_begin[rd_ptr];
      end

      if (state_q == S_ISSUE) begin
        tmo_cnt <= TIMEOUT_CYCLES;
      end else if (state_q == S_WAIT && !bus.wr_ctrl_rdy) begin
        tmo_cnt <= tmo_cnt - 16'd1;
      end

      if (state_q == S_WAIT && bus.wr_ctrl_rdy) wrap_q <= bus.capt_buf_wrap;

      // clear takes priority over any coincident increment
      if (ctrl_clear) begin
        pkt_count  <= '0;
        byte_count <= '0;
        wrap_count <= '0;
        drop_count <= '0;
        err        <= 1'b0;
      end else begin
        if (retire) begin
          pkt_count  <= pkt_next;
          byte_count <= byte_count + len_q;
          if (wrap_q) wrap_count <= wrap_count + 16'd1;
        end
        if (drop)   drop_count <= drop_count + 32'd1;
        if (expire) err        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capt_sched.sv
// Directed bench for capt_sched: single packet, burst overflow, invalid
// lengths, packet limit, watchdog and clear collisions.
module tb_capt_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_enable;
  logic        ctrl_clear;
  logic [31:0] max_pkts;
  logic        busy;
  logic [31:0] pkt_count, byte_count, drop_count;
  logic [15:0] wrap_count;
  logic        err, irq_done, irq_err;

  int n_cmp = 0;
  int n_err = 0;

  capt_sched_if bif ();

  // watchdog shortened so the timeout path is reachable in a short run
  capt_sched #(
    .DEPTH          (4),
    .MAX_PKT_BYTES  (16'd2048),
    .TIMEOUT_CYCLES (16'd24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_enable (ctrl_enable),
    .ctrl_clear  (ctrl_clear),
    .max_pkts    (max_pkts),
    .bus         (bif),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .byte_count  (byte_count),
    .wrap_count  (wrap_count),
    .drop_count  (drop_count),
    .err         (err),
    .irq_done    (irq_done),
    .irq_err     (irq_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] b, input logic [31:0] e);
    bif.desc_valid = 1'b1;
    bif.desc_begin = b;
    bif.desc_end   = e;
    tick();
    bif.desc_valid = 1'b0;
  endtask

  task automatic rdy_pulse(input logic wrap);
    bif.wr_ctrl_rdy   = 1'b1;
    bif.capt_buf_wrap = wrap;
    tick();
    bif.wr_ctrl_rdy   = 1'b0;
    bif.capt_buf_wrap = 1'b0;
  endtask

  task automatic clear_pulse();
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
  endtask

  task automatic wait_wr(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bif.wr_ctrl === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bif.wr_ctrl !== 1'b0 || busy !== 1'b0) pulses++;
    end
  endtask

  initial begin
    int  busy_cycles;
    int  wr_pulses;
    int  activity;
    bit  seen;

    reset             = 1'b0;
    ctrl_enable       = 1'b0;
    ctrl_clear        = 1'b0;
    max_pkts          = 32'd0;
    bif.desc_valid    = 1'b0;
    bif.desc_begin    = '0;
    bif.desc_end      = '0;
    bif.wr_ctrl_rdy   = 1'b0;
    bif.capt_buf_wrap = 1'b0;
    #2 reset = 1'b1;
    tick();
    tick();
    check("rst_desc_ready", 32'(bif.desc_ready), 32'd0);
    check("rst_wr_ctrl",    32'(bif.wr_ctrl),    32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_pkt_count",  pkt_count,           32'd0);
    check("rst_pkt_begin",  bif.pkt_begin,       32'd0);
    check("rst_err",        32'(err),            32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_desc_ready", 32'(bif.desc_ready), 32'd1);

    // single packet: rdy 20 cycles after the wr_ctrl cycle
    ctrl_enable = 1'b1;
    send(32'h100, 32'h140);
    check("t1_queued_no_issue", 32'(bif.wr_ctrl), 32'd0);
    tick();
    check("t1_wr_ctrl",   32'(bif.wr_ctrl), 32'd1);
    check("t1_pkt_begin", bif.pkt_begin,    32'h100);
    check("t1_pkt_end",   bif.pkt_end,      32'h140);
    check("t1_busy",      32'(busy),        32'd1);
    busy_cycles = 1;
    wr_pulses   = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy)        busy_cycles++;
      if (bif.wr_ctrl) wr_pulses++;
    end
    rdy_pulse(1'b0);
    check("t1_retire_busy", 32'(busy), 32'd0);
    tick();
    check("t1_busy_cycles", 32'(busy_cycles), 32'd21);
    check("t1_wr_pulses",   32'(wr_pulses),   32'd1);
    check("t1_pkt_count",   pkt_count,        32'd1);
    check("t1_byte_count",  byte_count,       32'd64);

    // burst of six with the writer stalled
    clear_pulse();
    check("t2_clear_pkt",  pkt_count,  32'd0);
    check("t2_clear_byte", byte_count, 32'd0);
    bif.desc_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bif.desc_begin = 32'h1000 * (i + 1);
      bif.desc_end   = 32'h1000 * (i + 1) + 32'd16 * (i + 1);
      tick();
      if (i == 1) begin
        check("t2_first_wr_ctrl", 32'(bif.wr_ctrl), 32'd1);
        check("t2_first_begin",   bif.pkt_begin,    32'h1000);
        check("t2_first_end",     bif.pkt_end,      32'h1010);
      end
    end
    bif.desc_valid = 1'b0;
    check("t2_drop_count", drop_count, 32'd1);
    check("t2_busy",       32'(busy),  32'd1);
    rdy_pulse(1'b0);
    tick();
    for (int i = 1; i < 5; i++) begin
      wait_wr(seen);
      check("t2_issue_seen", 32'(seen),    32'd1);
      check("t2_order_begin", bif.pkt_begin, 32'h1000 * (i + 1));
      check("t2_order_end",   bif.pkt_end,   32'h1000 * (i + 1) + 32'd16 * (i + 1));
      tick();
      rdy_pulse(1'b0);
      tick();
    end
    check("t2_pkt_count",  pkt_count,  32'd5);
    check("t2_byte_count", byte_count, 32'd240);
    check("t2_drop_final", drop_count, 32'd1);

    // invalid lengths, disabled capture, then the largest legal length
    clear_pulse();
    send(32'h200, 32'h200);
    send(32'h300, 32'h2FF);
    send(32'h0,   32'd2049);
    ctrl_enable = 1'b0;
    send(32'h400, 32'h410);
    ctrl_enable = 1'b1;
    watch(3, activity);
    check("t3_drop_count", drop_count,      32'd4);
    check("t3_no_issue",   32'(activity),   32'd0);
    send(32'h0, 32'h800);
    tick();
    check("t3_max_len_issue", 32'(bif.wr_ctrl), 32'd1);
    tick();
    rdy_pulse(1'b0);
    tick();
    check("t3_max_len_bytes", byte_count, 32'd2048);
    check("t3_drop_kept",     drop_count, 32'd4);

    // packet limit of two
    clear_pulse();
    max_pkts = 32'd2;
    send(32'h10, 32'h18);
    send(32'h20, 32'h28);
    tick();
    rdy_pulse(1'b0);
    tick();
    check("t4_pkt1",         pkt_count,         32'd1);
    check("t4_no_irq_early", 32'(irq_done),     32'd0);
    tick();
    check("t4_second_issue", 32'(bif.wr_ctrl),  32'd1);
    check("t4_second_begin", bif.pkt_begin,     32'h20);
    tick();
    rdy_pulse(1'b0);
    tick();
    check("t4_irq_done",   32'(irq_done), 32'd1);
    check("t4_pkt2",       pkt_count,     32'd2);
    check("t4_bytes",      byte_count,    32'd16);
    send(32'h30, 32'h38);
    check("t4_halt_drop",  drop_count,    32'd1);
    check("t4_irq_pulse",  32'(irq_done), 32'd0);
    watch(3, activity);
    check("t4_halt_idle",  32'(activity), 32'd0);
    max_pkts = 32'd0;
    clear_pulse();
    check("t4_clr_pkt",  pkt_count,  32'd0);
    check("t4_clr_byte", byte_count, 32'd0);
    check("t4_clr_drop", drop_count, 32'd0);
    send(32'h40, 32'h48);
    tick();
    check("t4_idle_after_clear", 32'(bif.wr_ctrl), 32'd1);
    tick();
    rdy_pulse(1'b0);
    tick();

    // watchdog expiry with a descriptor still queued
    clear_pulse();
    send(32'h500, 32'h510);
    send(32'h600, 32'h610);
    tick();
    for (int i = 0; i < 23; i++) tick();
    check("t5_pre_expiry_err",  32'(err),     32'd0);
    check("t5_pre_expiry_busy", 32'(busy),    32'd1);
    tick();
    check("t5_irq_err", 32'(irq_err), 32'd1);
    check("t5_err",     32'(err),     32'd1);
    check("t5_busy",    32'(busy),    32'd0);
    tick();
    check("t5_irq_pulse", 32'(irq_err), 32'd0);
    check("t5_err_sticky", 32'(err),    32'd1);
    watch(4, activity);
    check("t5_no_issue_in_error", 32'(activity), 32'd0);
    check("t5_no_retire",         pkt_count,     32'd0);
    send(32'h700, 32'h710);
    check("t5_error_drop", drop_count, 32'd1);
    clear_pulse();
    check("t5_clr_err",  32'(err),   32'd0);
    check("t5_clr_drop", drop_count, 32'd0);
    watch(3, activity);
    check("t5_flushed", 32'(activity), 32'd0);

    // rdy arriving on the expiry cycle wins
    send(32'h800, 32'h810);
    tick();
    tick();
    for (int i = 0; i < 23; i++) tick();
    rdy_pulse(1'b0);
    check("t5b_no_err",     32'(err),     32'd0);
    check("t5b_no_irq_err", 32'(irq_err), 32'd0);
    tick();
    check("t5b_pkt",   pkt_count,  32'd1);
    check("t5b_bytes", byte_count, 32'd16);

    // wrap counting, then clear colliding with retire and a drop
    send(32'h900, 32'h920);
    tick();
    tick();
    rdy_pulse(1'b1);
    tick();
    check("t6_wrap", 32'(wrap_count), 32'd1);
    check("t6_pkt",  pkt_count,       32'd2);
    check("t6_byte", byte_count,      32'h30);
    send(32'hA00, 32'hA20);
    tick();
    tick();
    rdy_pulse(1'b1);
    ctrl_clear     = 1'b1;
    bif.desc_valid = 1'b1;
    bif.desc_begin = 32'hB00;
    bif.desc_end   = 32'hB00;
    tick();
    ctrl_clear     = 1'b0;
    bif.desc_valid = 1'b0;
    check("t6_clr_pkt",  pkt_count,       32'd0);
    check("t6_clr_byte", byte_count,      32'd0);
    check("t6_clr_wrap", 32'(wrap_count), 32'd0);
    check("t6_clr_drop", drop_count,      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
